solver_dispatcher: RTL



---
 rtl/solver_dispatcher.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/solver_dispatcher.sv
// Packet scheduler: steers whole command packets to idle tile solvers and merges
// their results onto one output stream with round-robin arbitration.
module solver_dispatcher #(
  parameter int unsigned NUM_SOLVERS = 4,
  parameter int unsigned IDX_BITS    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [31:0]                out_addr,
  output logic [15:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [32*NUM_SOLVERS-1:0]  sol_in_data,
  output logic [NUM_SOLVERS-1:0]     sol_in_valid,
  input  logic [NUM_SOLVERS-1:0]     sol_in_ready,
  input  logic [32*NUM_SOLVERS-1:0]  sol_out_addr,
  input  logic [16*NUM_SOLVERS-1:0]  sol_out_data,
  input  logic [NUM_SOLVERS-1:0]     sol_out_valid,
  output logic [NUM_SOLVERS-1:0]     sol_out_ready,
  output logic [NUM_SOLVERS-1:0]     busy,
  output logic [31:0]                dispatched_count,
  output logic [31:0]                completed_count
);

  localparam logic [2:0]          TypeStart = 3'd4;
  localparam logic [IDX_BITS-1:0] LastIdx   = IDX_BITS'(NUM_SOLVERS - 1);

  typedef enum logic [0:0] {StSelect, StRoute} state_e;

  state_e                state_q;
  logic [IDX_BITS-1:0]   target_q;
  logic [NUM_SOLVERS-1:0] busy_q, busy_d;
  logic [IDX_BITS-1:0]   rr_ptr_q;
  logic                  lock_q;
  logic [IDX_BITS-1:0]   lock_idx_q;
  logic [31:0]           dispatched_q;
  logic [31:0]           completed_q;

  logic                  idle_found;
  logic [IDX_BITS-1:0]   idle_idx;
  logic                  in_fire, start_fire, out_fire;
  logic                  scan_found;
  logic [IDX_BITS-1:0]   scan_idx, cand, grant, rr_next;

  // Downward scan so the last hit is the lowest idle index.
  always_comb begin
    idle_found = 1'b0;
    idle_idx   = '0;
    for (int i = int'(NUM_SOLVERS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        idle_found = 1'b1;
        idle_idx   = IDX_BITS'(i);
      end
    end
  end

  assign sol_in_data = {NUM_SOLVERS{in_data}};

  always_comb begin
    in_ready     = 1'b0;
    sol_in_valid = '0;
    if (state_q == StRoute) begin
      in_ready = sol_in_ready[target_q];
      for (int i = 0; i < int'(NUM_SOLVERS); i++) begin
        sol_in_valid[i] = in_valid && (target_q == IDX_BITS'(i));
      end
    end
  end

  assign in_fire    = in_valid && in_ready;
  assign start_fire = in_fire && (in_data[31:29] == TypeStart);

  // Round-robin scan from rr_ptr with wrap; a stalled grant stays locked.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = rr_ptr_q;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
      cand = IDX_BITS'((32'(rr_ptr_q) + k) % NUM_SOLVERS);
      if (!scan_found && sol_out_valid[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
    end
    grant = (lock_q && sol_out_valid[lock_idx_q]) ? lock_idx_q : scan_idx;
  end

  assign out_valid = |sol_out_valid;
  assign out_fire  = out_valid && out_ready;
  assign rr_next   = (grant == LastIdx) ? '0 : grant + 1'b1;

  always_comb begin
    out_addr      = '0;
    out_data      = '0;
    sol_out_ready = '0;
    for (int i = 0; i < int'(NUM_SOLVERS); i++) begin
      if (grant == IDX_BITS'(i)) begin
        out_addr         = sol_out_addr[32*i +: 32];
        out_data         = sol_out_data[16*i +: 16];
        sol_out_ready[i] = out_ready;
      end
    end
  end

  // Set and clear never hit the same index: the routing target is idle.
  always_comb begin
    busy_d = busy_q & ~(sol_out_valid & sol_out_ready);
    if (start_fire) begin
      busy_d[target_q] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StSelect;
      target_q     <= '0;
      busy_q       <= '0;
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      dispatched_q <= '0;
      completed_q  <= '0;
    end else begin
      busy_q <= busy_d;
      unique case (state_q)
        StSelect: begin
          if (idle_found) begin
            target_q <= idle_idx;
            state_q  <= StRoute;
          end
        end
        StRoute: begin
          if (start_fire) begin
            state_q <= StSelect;
          end
        end
        default: state_q <= StSelect;
      endcase
      if (start_fire) begin
        dispatched_q <= dispatched_q + 32'd1;
      end
      if (out_fire) begin
        rr_ptr_q    <= rr_next;
        lock_q      <= 1'b0;
        completed_q <= completed_q + 32'd1;
      end else if (out_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
    end
  end

  assign busy             = busy_q;
  assign dispatched_count = dispatched_q;
  assign completed_count  = completed_q;

endmodule
